// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: reset/bubble constants, fetch FSM encoding and
// the major opcodes the decoder keys on.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0,x0,0
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    // state | meaning
    // START | one idle cycle after reset, no request
    // FETCH | request at pc outstanding
    // HOLD  | acked word parked in the skid buffer while decode stalls
    // DROP  | redirect arrived mid-request; finish the old request, then jump
    typedef enum logic [1:0] {
        START = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    function automatic logic [6:0] opcode_of(input logic [31:0] instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Flush beats stall beats load; a cycle without a
// delivered instruction loads a bubble but keeps the last pc for debug.
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        stall,
    input  logic        load_valid,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        valid
);

    // prioritized update of the {instr, pc, valid} triple
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= NOP_INSTR;
            pc    <= '0;
            valid <= 1'b0;
        end else if (flush) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (!stall) begin
            instr <= load_valid ? load_instr : NOP_INSTR;
            pc    <= load_valid ? load_pc : pc;
            valid <= load_valid;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the pc, runs a single-outstanding req/ack fetch to
// instruction memory and feeds the IF/ID register. imem_addr is the pc
// itself, so it is naturally stable for the life of a request (pc only moves
// on ack or on leaving HOLD, where no request is open).
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_valid
);
    import riscv_pkg::*;

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  buf_q, buf_d;
    logic [31:0]  pend_q, pend_d;
    logic         deliver;
    logic [31:0]  deliver_instr;

    assign imem_addr = pc_q;

    // state, pc, skid buffer and deferred redirect target
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= START;
            pc_q    <= RESET_PC;
            buf_q   <= NOP_INSTR;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            pend_q  <= pend_d;
        end
    end

    // next state, pc update, request and delivery decode
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        buf_d         = buf_q;
        pend_d        = pend_q;
        imem_req      = 1'b0;
        deliver       = 1'b0;
        deliver_instr = NOP_INSTR;
        case (state_q)
            START: state_d = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (redirect) begin
                        pc_d = redirect_pc;
                    end else if (stall) begin
                        buf_d   = imem_rdata;
                        state_d = HOLD;
                    end else begin
                        deliver       = 1'b1;
                        deliver_instr = imem_rdata;
                        pc_d          = pc_q + 32'd4;
                    end
                end else if (redirect) begin
                    pend_d  = redirect_pc;
                    state_d = DROP;
                end
            end
            HOLD: begin
                if (redirect) begin
                    buf_d   = NOP_INSTR;
                    pc_d    = redirect_pc;
                    state_d = FETCH;
                end else if (!stall) begin
                    deliver       = 1'b1;
                    deliver_instr = buf_q;
                    pc_d          = pc_q + 32'd4;
                    state_d       = FETCH;
                end
            end
            DROP: begin
                // old request must complete at its original address
                imem_req = 1'b1;
                if (imem_ack) begin
                    pc_d    = redirect ? redirect_pc : pend_q;
                    state_d = FETCH;
                end else if (redirect) begin
                    pend_d = redirect_pc;
                end
            end
            default: state_d = START;
        endcase
    end

    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush | redirect),
        .stall      (stall),
        .load_valid (deliver),
        .load_instr (deliver_instr),
        .load_pc    (pc_q),
        .instr      (id_instr),
        .pc         (id_pc),
        .valid      (id_valid)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: a directed walk through reset, streaming, wait
// states, stall, redirect and flush, then a randomized run where a memory
// responder with random latency feeds the stage and a scoreboard checks that
// ID sees program order (pc, pc+4, ... restarting at each redirect target).
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_valid;

    int n_pass  = 0;
    int n_total = 0;
    int n_deliv = 0;
    bit sb_en   = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;

    if_fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_valid    (id_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    task automatic chk_id(input string name, input logic [31:0] ins,
                          input logic [31:0] pc, input logic v);
        chk({name, "_instr"}, id_instr, ins);
        chk({name, "_pc"}, id_pc, pc);
        chk({name, "_valid"}, {31'd0, id_valid}, {31'd0, v});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor: a fresh IF/ID load with valid set must be the next
    // instruction in program order
    always @(negedge clk) begin
        if (sb_en && id_valid && !(stall && !flush && !redirect)) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL sb_empty: got pc %08h with nothing expected", id_pc);
            end else begin
                exp_pc = exp_q.pop_front();
                chk("sb_pc", id_pc, exp_pc);
                chk("sb_instr", id_instr, mem_word(exp_pc));
                exp_q.push_back(exp_pc + 32'd4);
                n_deliv++;
            end
        end
    end

    initial begin
        int wait_cnt;
        logic [31:0] req_addr;

        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = '0;

        // reset
        repeat (3) tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk_id("rst", NOP, 32'h0, 1'b0);
        rst_n = 1'b1;
        #1 chk("start_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);

        // zero-wait stream
        imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
        tick(); chk_id("s0", 32'h0050_0093, 32'h0, 1'b1); chk("s0_addr", imem_addr, 32'h4);
        imem_rdata = 32'h00A0_0113;
        tick(); chk_id("s1", 32'h00A0_0113, 32'h4, 1'b1); chk("s1_addr", imem_addr, 32'h8);
        imem_rdata = 32'h0020_81B3;
        tick(); chk_id("s2", 32'h0020_81B3, 32'h8, 1'b1); chk("s2_addr", imem_addr, 32'hC);

        // three wait states
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ws_addr", imem_addr, 32'hC);
            chk("ws_req", {31'd0, imem_req}, 32'd1);
            chk("ws_valid", {31'd0, id_valid}, 32'd0);
        end
        imem_ack = 1'b1; imem_rdata = 32'h0030_0213;
        tick(); chk_id("ws", 32'h0030_0213, 32'hC, 1'b1); chk("ws_next", imem_addr, 32'h10);

        // stall on ack: word parks in the skid buffer
        imem_rdata = 32'h00C0_0193; stall = 1'b1;
        tick();
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        chk_id("hold0", 32'h0030_0213, 32'hC, 1'b1);
        imem_rdata = 32'hDEAD_BEEF;     // stray ack while idle must be ignored
        tick();
        chk("hold1_req", {31'd0, imem_req}, 32'd0);
        chk_id("hold1", 32'h0030_0213, 32'hC, 1'b1);
        stall = 1'b0; imem_ack = 1'b0;
        tick(); chk_id("unhold", 32'h00C0_0193, 32'h10, 1'b1);
        chk("unhold_addr", imem_addr, 32'h14);
        chk("unhold_req", {31'd0, imem_req}, 32'd1);

        // advance to 0x20
        imem_ack = 1'b1; imem_rdata = 32'h0010_0293; tick();
        imem_rdata = 32'h0020_0313; tick();
        imem_rdata = 32'h0030_0393; tick();
        chk_id("pre_redir", 32'h0030_0393, 32'h1C, 1'b1);
        chk("pre_redir_addr", imem_addr, 32'h20);

        // redirect while 0x20 is outstanding; ack two cycles later
        imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
        tick(); chk("drop0_valid", {31'd0, id_valid}, 32'd0); chk("drop0_addr", imem_addr, 32'h20);
        chk("drop0_req", {31'd0, imem_req}, 32'd1);
        redirect = 1'b0;
        tick(); chk("drop1_valid", {31'd0, id_valid}, 32'd0); chk("drop1_addr", imem_addr, 32'h20);
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_0013;
        tick(); chk("drop2_valid", {31'd0, id_valid}, 32'd0); chk("drop2_addr", imem_addr, 32'h100);
        chk("drop2_req", {31'd0, imem_req}, 32'd1);
        imem_rdata = 32'h1000_0093;
        tick(); chk_id("tgt", 32'h1000_0093, 32'h100, 1'b1);

        // flush and stall together
        imem_ack = 1'b0; stall = 1'b1; flush = 1'b1;
        tick(); chk_id("flush", NOP, 32'h100, 1'b0); chk("flush_addr", imem_addr, 32'h104);

        // redirect with ack to the top of memory, then wrap
        stall = 1'b0; flush = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick(); chk("rack_valid", {31'd0, id_valid}, 32'd0); chk("rack_addr", imem_addr, 32'hFFFF_FFFC);
        redirect = 1'b0; imem_rdata = 32'h7FF0_0413;
        tick(); chk_id("wrap", 32'h7FF0_0413, 32'hFFFF_FFFC, 1'b1); chk("wrap_addr", imem_addr, 32'h0);

        // randomized phase from a fresh reset
        imem_ack = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        exp_q.delete();
        exp_q.push_back(32'h0);
        wait_cnt = -1;
        req_addr = '0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        sb_en = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk); #1;
            if (imem_req) begin
                if (wait_cnt < 0) begin
                    wait_cnt = ($urandom % 2 == 0) ? 0 : int'($urandom_range(1, 3));
                    req_addr = imem_addr;
                end else begin
                    chk("addr_stable", imem_addr, req_addr);
                end
                if (wait_cnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    wait_cnt   = -1;
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = $urandom;
                    wait_cnt--;
                end
            end else begin
                wait_cnt   = -1;
                imem_ack   = ($urandom % 8 == 0);
                imem_rdata = $urandom;
            end
            stall       = ($urandom % 4 == 0);
            redirect    = (cyc > 4) && ($urandom % 12 == 0);
            redirect_pc = ($urandom % 8 == 0) ? ($urandom & 32'hFFFF_FFFC)
                                              : ($urandom_range(0, 511) << 2);
            flush       = (stall || redirect) && ($urandom % 2 == 1);
            if (redirect) begin
                exp_q.delete();
                exp_q.push_back(redirect_pc);
            end
        end
        @(negedge clk);
        sb_en = 1'b0;

        n_total++;
        if (n_deliv >= 200) n_pass++;
        else $display("FAIL progress: got %0d deliveries expected at least 200", n_deliv);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
